// File: rtl/memory_arbiter_if.sv
// Cache-side request/response and RAM-side handshake bundle for memory_arbiter.
// The slave modport is the arbiter's view; master is the surrounding cache/RAM environment.
interface memory_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [ADDR_W-1:0] iload;
  logic [ADDR_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto one RAM port: data wins by default,
// but after STARVE_LIMIT data grants with an instruction fetch waiting, the fetch is forced through.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
);

  localparam int unsigned      CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  localparam logic [1:0]       RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] store_r, store_s;
  logic              write_r, write_s;
  logic [CNT_W-1:0]  streak_r, streak_s;

  logic              d_req_s;
  logic              ram_ren_s, ram_wen_s;
  logic [ADDR_W-1:0] ram_addr_s, ram_store_s;
  logic              iwait_s, dwait_s;

  assign d_req_s = bus.dREN | bus.dWEN;

  // State, latched request and starvation streak registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      addr_r   <= '0;
      store_r  <= '0;
      write_r  <= 1'b0;
      streak_r <= '0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      store_r  <= store_s;
      write_r  <= write_s;
      streak_r <= streak_s;
    end
  end

  // Arbitration, RAM handshake sequencing and cache-side wait generation.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    store_s     = store_r;
    write_s     = write_r;
    streak_s    = streak_r;
    ram_ren_s   = 1'b0;
    ram_wen_s   = 1'b0;
    ram_addr_s  = '0;
    ram_store_s = '0;
    iwait_s     = 1'b1;
    dwait_s     = 1'b1;

    case (state_r)
      IDLE: begin
        if (bus.iREN && (!d_req_s || (streak_r == STREAK_MAX))) begin
          state_s  = GRANT_I;
          addr_s   = bus.iaddr;
          streak_s = '0;
        end else if (d_req_s) begin
          state_s = GRANT_D;
          addr_s  = bus.daddr;
          store_s = bus.dstore;
          write_s = bus.dWEN;
          // Only data grants that pass over a waiting fetch count toward starvation.
          if (!bus.iREN) begin
            streak_s = '0;
          end else if (streak_r == STREAK_MAX) begin
            streak_s = streak_r;
          end else begin
            streak_s = streak_r + CNT_W'(1);
          end
        end else begin
          state_s = IDLE;
        end
      end

      GRANT_I: begin
        if (!bus.iREN) begin
          state_s = IDLE;
        end else begin
          ram_ren_s  = 1'b1;
          ram_addr_s = addr_r;
          if (bus.ramstate == RAM_ACCESS) begin
            iwait_s = 1'b0;
            state_s = IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            state_s = IDLE;
          end else begin
            state_s = GRANT_I;
          end
        end
      end

      GRANT_D: begin
        if (!d_req_s) begin
          state_s = IDLE;
        end else begin
          ram_ren_s   = ~write_r;
          ram_wen_s   = write_r;
          ram_addr_s  = addr_r;
          ram_store_s = store_r;
          if (bus.ramstate == RAM_ACCESS) begin
            dwait_s = 1'b0;
            state_s = IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            state_s = IDLE;
          end else begin
            state_s = GRANT_D;
          end
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.ramREN   = ram_ren_s;
  assign bus.ramWEN   = ram_wen_s;
  assign bus.ramaddr  = ram_addr_s;
  assign bus.ramstore = ram_store_s;
  assign bus.iwait    = iwait_s;
  assign bus.dwait    = dwait_s;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int unsigned STARVE = 4;

  logic CLK;
  logic nRST;

  memory_arbiter_if #(.ADDR_W(32)) bus();

  memory_arbiter #(.STARVE_LIMIT(STARVE), .ADDR_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the RAM port, what was latched, and the data streak.
  int          m_owner;   // 0 none, 1 instruction, 2 data
  logic [31:0] m_addr;
  logic [31:0] m_store;
  bit          m_write;
  int          m_streak;

  // Completion history observed on the DUT wait lines: 1 = I, 0 = D (newest in bit 0).
  logic [31:0] obs_bits;
  int          obs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; ends on the next falling edge.
  task automatic step();
    bit          active;
    bit          dreq;
    logic        e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    #1;
    dreq   = bus.dREN | bus.dWEN;
    active = 1'b0;
    e_ren  = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
    e_addr = 32'd0; e_store = 32'd0;
    if (nRST && m_owner != 0) begin
      active = (m_owner == 1) ? bus.iREN : dreq;
      if (active) begin
        e_addr = m_addr;
        if (m_owner == 1) begin
          e_ren = 1'b1;
        end else begin
          e_ren   = !m_write;
          e_wen   = m_write;
          e_store = m_store;
        end
        if (bus.ramstate == 2'd2) begin
          if (m_owner == 1) e_iw = 1'b0;
          else              e_dw = 1'b0;
        end
      end
    end
    check_eq("ramREN",   {31'd0, bus.ramREN}, {31'd0, e_ren});
    check_eq("ramWEN",   {31'd0, bus.ramWEN}, {31'd0, e_wen});
    check_eq("ramaddr",  bus.ramaddr,  e_addr);
    check_eq("ramstore", bus.ramstore, e_store);
    check_eq("iwait",    {31'd0, bus.iwait},  {31'd0, e_iw});
    check_eq("dwait",    {31'd0, bus.dwait},  {31'd0, e_dw});
    check_eq("iload",    bus.iload, bus.ramload);
    check_eq("dload",    bus.dload, bus.ramload);
    if (!bus.iwait) begin obs_bits = {obs_bits[30:0], 1'b1}; obs_cnt++; end
    if (!bus.dwait) begin obs_bits = {obs_bits[30:0], 1'b0}; obs_cnt++; end

    // Advance the model to what the next rising edge should produce.
    if (!nRST) begin
      m_owner  = 0;
      m_streak = 0;
    end else if (m_owner == 0) begin
      if (bus.iREN && (!dreq || m_streak == STARVE)) begin
        m_owner  = 1;
        m_addr   = bus.iaddr;
        m_streak = 0;
      end else if (dreq) begin
        m_owner  = 2;
        m_addr   = bus.daddr;
        m_store  = bus.dstore;
        m_write  = bus.dWEN;
        m_streak = bus.iREN ? ((m_streak < STARVE) ? m_streak + 1 : STARVE) : 0;
      end
    end else if (!active || bus.ramstate == 2'd2 || bus.ramstate == 2'd3) begin
      m_owner = 0;
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.iaddr = 32'd0; bus.daddr = 32'd0; bus.dstore = 32'd0;
    bus.ramload = 32'd0; bus.ramstate = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    obs_bits = 32'd0;
    obs_cnt  = 0;
  endtask

  initial begin
    m_owner = 0; m_addr = 32'd0; m_store = 32'd0; m_write = 1'b0; m_streak = 0;
    obs_bits = 32'd0; obs_cnt = 0;
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    step();
    do_reset();

    // Single instruction read: two BUSY cycles, then ACCESS.
    bus.iREN = 1'b1; bus.iaddr = 32'h100; bus.ramstate = 2'd1;
    step();
    step();
    step();
    bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
    step();
    check_eq("single_i_done", {31'd0, obs_bits[0]}, 32'd1);
    check_eq("single_i_count", obs_cnt, 32'd1);
    bus.iREN = 1'b0;
    step();

    // Contention: data wins, fetch follows once data goes quiet.
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.dREN = 1'b1; bus.daddr = 32'h200;
    bus.ramstate = 2'd2; bus.ramload = 32'h0000_5A5A;
    step();
    step();
    bus.dREN = 1'b0;
    step();
    step();
    check_eq("contention_order", obs_bits & 32'h3, 32'h1);
    check_eq("contention_count", obs_cnt, 32'd2);

    // Starvation guard with iREN and dWEN held.
    do_reset();
    bus.iREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hA5A5_0001;
    bus.ramstate = 2'd2;
    for (int i = 0; i < 20; i++) step();
    check_eq("starve_seq", obs_bits & 32'h3FF, 32'b00001_00001);
    check_eq("starve_count", obs_cnt, 32'd10);

    // Plain write with a BUSY stretch.
    do_reset();
    bus.dWEN = 1'b1; bus.daddr = 32'h40; bus.dstore = 32'h12345678; bus.ramstate = 2'd1;
    step();
    step();
    bus.ramstate = 2'd2;
    step();
    bus.dWEN = 1'b0;
    step();
    check_eq("write_done", obs_cnt, 32'd1);

    // ERROR on the first data grant, then retry.
    do_reset();
    bus.dREN = 1'b1; bus.daddr = 32'h44; bus.ramstate = 2'd3;
    step();
    step();
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE_F00D;
    step();
    step();
    bus.dREN = 1'b0;
    step();
    check_eq("error_retry_count", obs_cnt, 32'd1);

    // Abort: data request withdrawn while RAM is busy.
    do_reset();
    bus.dREN = 1'b1; bus.daddr = 32'h48; bus.ramstate = 2'd1;
    step();
    step();
    bus.dREN = 1'b0;
    step();
    bus.ramstate = 2'd2;
    step();
    check_eq("abort_no_done", obs_cnt, 32'd0);

    // Asynchronous reset in the middle of an instruction grant.
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = 2'd1;
    step();
    step();
    #2 nRST = 1'b0;
    #1;
    check_eq("async_rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    check_eq("async_rst_iwait",  {31'd0, bus.iwait},  32'd1);
    @(negedge CLK);
    step();
    nRST = 1'b1;
    bus.ramstate = 2'd2;
    step();
    step();
    bus.iREN = 1'b0;
    step();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(7) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(9) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(11) == 0) bus.dWEN = ~bus.dWEN;
      bus.iaddr   = $urandom;
      bus.daddr   = $urandom;
      bus.dstore  = $urandom;
      bus.ramload = $urandom;
      r = $urandom_range(9);
      if (r < 4)       bus.ramstate = 2'd1;
      else if (r == 4) bus.ramstate = 2'd0;
      else if (r < 9)  bus.ramstate = 2'd2;
      else             bus.ramstate = 2'd3;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
